// File: rtl/traffic_phase_scheduler.sv
// Two-road junction sequencer: self-timed green/amber/all-red phases driven by
// vehicle and pedestrian demand, with a flashing-amber night mode.
module traffic_phase_scheduler #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       modo,
    input  logic       sens_a,
    input  logic       sens_b,
    input  logic       ped_a_req,
    input  logic       ped_b_req,
    output logic       VmA,
    output logic       AmA,
    output logic       VdA,
    output logic       VmB,
    output logic       AmB,
    output logic       VdB,
    output logic       walk_a,
    output logic       walk_b,
    output logic [2:0] phase
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PW   = $clog2(TICK_DIV);
    localparam int TMAX = imax(imax(imax(GREEN_MAX, GREEN_MIN), imax(YELLOW_T, ALLRED_T)), WALK_T);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GMIN_M1  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_M1  = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] YEL_M1   = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_M1    = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] WALK_C   = TW'(WALK_T);

    typedef enum logic [2:0] {
        GA    = 3'd0,
        YA    = 3'd1,
        RR1   = 3'd2,
        GB    = 3'd3,
        YB    = 3'd4,
        RR2   = 3'd5,
        N_ON  = 3'd6,
        N_OFF = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          pa_l_q, pa_l_d, pb_l_q, pb_l_d;
    logic          walk_a_en_q, walk_a_en_d, walk_b_en_q, walk_b_en_d;
    logic          from_ya_q, from_ya_d;
    logic          tick, chg, dem_a, dem_b, tcnt_hold;

    assign tick  = (pre_q == PRE_LAST);
    assign dem_b = sens_b | pa_l_q;
    assign dem_a = sens_a | pb_l_q;

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                GA:    if (modo || (dem_b && (tcnt_q >= GMIN_M1 || tcnt_q == GMAX_M1))) state_d = YA;
                YA:    if (tcnt_q == YEL_M1) state_d = RR1;
                // RR1 leads to GB only when entered from YA; after reset or night mode it opens A
                RR1:   if (modo) state_d = N_ON;
                       else if (tcnt_q == AR_M1) state_d = from_ya_q ? GB : GA;
                GB:    if (modo || (dem_a && (tcnt_q >= GMIN_M1 || tcnt_q == GMAX_M1))) state_d = YB;
                YB:    if (tcnt_q == YEL_M1) state_d = RR2;
                RR2:   if (modo) state_d = N_ON;
                       else if (tcnt_q == AR_M1) state_d = GA;
                N_ON:  state_d = modo ? N_OFF : RR1;
                N_OFF: state_d = modo ? N_ON : RR1;
                default: state_d = RR1;
            endcase
        end
    end

    always_comb begin
        chg       = (state_d != state_q);
        pre_d     = tick ? '0 : pre_q + 1'b1;
        tcnt_hold = ((state_q == GA || state_q == GB) && tcnt_q == GMAX_M1) || (&tcnt_q);
        tcnt_d    = tcnt_q;
        if (chg)
            tcnt_d = '0;
        else if (tick && !tcnt_hold)
            tcnt_d = tcnt_q + 1'b1;
        // a request arriving in the same cycle as the clearing entry survives
        pa_l_d      = ped_a_req | (pa_l_q & ~(chg && state_d == GB));
        pb_l_d      = ped_b_req | (pb_l_q & ~(chg && state_d == GA));
        walk_a_en_d = (chg && state_d == GB) ? pa_l_q : walk_a_en_q;
        walk_b_en_d = (chg && state_d == GA) ? pb_l_q : walk_b_en_q;
        from_ya_d   = (chg && state_d == RR1) ? (state_q == YA) : from_ya_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RR1;
            pre_q       <= '0;
            tcnt_q      <= '0;
            pa_l_q      <= 1'b0;
            pb_l_q      <= 1'b0;
            walk_a_en_q <= 1'b0;
            walk_b_en_q <= 1'b0;
            from_ya_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            tcnt_q      <= tcnt_d;
            pa_l_q      <= pa_l_d;
            pb_l_q      <= pb_l_d;
            walk_a_en_q <= walk_a_en_d;
            walk_b_en_q <= walk_b_en_d;
            from_ya_q   <= from_ya_d;
        end
    end

    always_comb begin
        {VmA, AmA, VdA, VmB, AmB, VdB} = 6'b000000;
        case (state_q)
            GA:       {VdA, VmB} = 2'b11;
            YA:       {AmA, VmB} = 2'b11;
            RR1, RR2: {VmA, VmB} = 2'b11;
            GB:       {VmA, VdB} = 2'b11;
            YB:       {VmA, AmB} = 2'b11;
            N_ON:     {AmA, AmB} = 2'b11;
            default:  {VmA, AmA, VdA, VmB, AmB, VdB} = 6'b000000;
        endcase
        walk_a = (state_q == GB) && walk_a_en_q && (tcnt_q < WALK_C);
        walk_b = (state_q == GA) && walk_b_en_q && (tcnt_q < WALK_C);
        phase  = state_q;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Tick-aligned scoreboard bench for traffic_phase_scheduler (TICK_DIV=4).
module tb_traffic_phase_scheduler;

    logic clk = 1'b0, rst = 1'b1, modo = 1'b0;
    logic sens_a = 1'b0, sens_b = 1'b0, ped_a_req = 1'b0, ped_b_req = 1'b0;
    logic VmA, AmA, VdA, VmB, AmB, VdB, walk_a, walk_b;
    logic [2:0] phase;
    logic VmA2, AmA2, VdA2, VmB2, AmB2, VdB2, walk_a2, walk_b2;
    logic [2:0] phase2;

    localparam logic [2:0] P_GA = 3'd0, P_YA = 3'd1, P_RR1 = 3'd2, P_GB = 3'd3,
                           P_YB = 3'd4, P_RR2 = 3'd5, P_NON = 3'd6, P_NOFF = 3'd7;

    typedef struct packed {
        logic [2:0] ph;
        logic       wa;
        logic       wb;
    } exp_t;

    exp_t       q[$];
    logic [2:0] q2[$];
    int checks = 0, errors = 0, sidx = 0;
    string cur = "";

    always #5 clk = ~clk;

    traffic_phase_scheduler #(.TICK_DIV(4), .GREEN_MIN(2), .GREEN_MAX(4), .YELLOW_T(1),
                              .ALLRED_T(1), .WALK_T(1)) dut (
        .clk(clk), .rst(rst), .modo(modo), .sens_a(sens_a), .sens_b(sens_b),
        .ped_a_req(ped_a_req), .ped_b_req(ped_b_req),
        .VmA(VmA), .AmA(AmA), .VdA(VdA), .VmB(VmB), .AmB(AmB), .VdB(VdB),
        .walk_a(walk_a), .walk_b(walk_b), .phase(phase));

    traffic_phase_scheduler #(.TICK_DIV(4), .GREEN_MIN(4), .GREEN_MAX(4), .YELLOW_T(1),
                              .ALLRED_T(1), .WALK_T(1)) dut2 (
        .clk(clk), .rst(rst), .modo(modo), .sens_a(sens_a), .sens_b(sens_b),
        .ped_a_req(ped_a_req), .ped_b_req(ped_b_req),
        .VmA(VmA2), .AmA(AmA2), .VdA(VdA2), .VmB(VmB2), .AmB(AmB2), .VdB(VdB2),
        .walk_a(walk_a2), .walk_b(walk_b2), .phase(phase2));

    // {VmA,AmA,VdA,VmB,AmB,VdB}
    function automatic logic [5:0] lamps_of(input logic [2:0] ph);
        case (ph)
            3'd0:       return 6'b001100;
            3'd1:       return 6'b010100;
            3'd2, 3'd5: return 6'b100100;
            3'd3:       return 6'b100001;
            3'd4:       return 6'b100010;
            3'd6:       return 6'b010010;
            default:    return 6'b000000;
        endcase
    endfunction

    task automatic push(input logic [2:0] ph, input logic wa, input logic wb);
        exp_t e;
        e.ph = ph; e.wa = wa; e.wb = wb;
        q.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        logic [2:0] e2;
        logic [5:0] lam;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s s%0d scoreboard: no expectation queued", cur, sidx);
        end else begin
            e = q.pop_front();
            lam = {VmA, AmA, VdA, VmB, AmB, VdB};
            if (phase !== e.ph) begin
                errors++;
                $display("FAIL %s s%0d phase: got %0d want %0d", cur, sidx, phase, e.ph);
            end
            checks++;
            if (lam !== lamps_of(e.ph)) begin
                errors++;
                $display("FAIL %s s%0d lamps: got %b want %b", cur, sidx, lam, lamps_of(e.ph));
            end
            checks++;
            if ({walk_a, walk_b} !== {e.wa, e.wb}) begin
                errors++;
                $display("FAIL %s s%0d walk a/b: got %b%b want %b%b", cur, sidx, walk_a, walk_b, e.wa, e.wb);
            end
            checks++;
            if ((VdA & VdB) !== 1'b0) begin
                errors++;
                $display("FAIL %s s%0d safety: both greens lit", cur, sidx);
            end
        end
        if (q2.size() > 0) begin
            e2 = q2.pop_front();
            checks++;
            if (phase2 !== e2) begin
                errors++;
                $display("FAIL %s s%0d phase(gmin4): got %0d want %0d", cur, sidx, phase2, e2);
            end
        end
        sidx++;
    endtask

    // advance exactly one tick (4 clocks), optionally pulsing a ped button for the first clock
    task automatic step(input bit pa, input bit pb);
        ped_a_req = pa;
        ped_b_req = pb;
        @(negedge clk);
        ped_a_req = 1'b0;
        ped_b_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (phase !== P_RR1 || {VmA, AmA, VdA, VmB, AmB, VdB} !== 6'b100100 || {walk_a, walk_b} !== 2'b00) begin
            errors++;
            $display("FAIL %s reset outputs: phase %0d lamps %b walk %b%b want 2 100100 00",
                     cur, phase, {VmA, AmA, VdA, VmB, AmB, VdB}, walk_a, walk_b);
        end
        checks++;
        if ({dut.pa_l_q, dut.pb_l_q} !== 2'b00) begin
            errors++;
            $display("FAIL %s reset latches: got %b want 00", cur, {dut.pa_l_q, dut.pb_l_q});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sidx = 0;
        push(P_RR1, 0, 0);
        compare();
    endtask

    task automatic test_reset();
        cur = "reset";
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (phase !== P_RR1) begin
                errors++;
                $display("FAIL reset pre-tick clk%0d phase: got %0d want 2", i, phase);
            end
        end
        @(negedge clk);
        checks++;
        if (phase !== P_GA) begin
            errors++;
            $display("FAIL reset first-tick phase: got %0d want 0", phase);
        end
        for (int i = 0; i < 20; i++) begin
            push(P_GA, 0, 0);
            step(0, 0);
        end
    endtask

    task automatic test_alternate();
        cur = "alternate";
        sens_a = 1'b1; sens_b = 1'b1;
        do_reset();
        push(P_GA, 0, 0); push(P_GA, 0, 0); push(P_YA, 0, 0); push(P_RR1, 0, 0);
        push(P_GB, 0, 0); push(P_GB, 0, 0); push(P_YB, 0, 0); push(P_RR2, 0, 0);
        push(P_GA, 0, 0); push(P_GA, 0, 0); push(P_YA, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0);
        sens_a = 1'b0; sens_b = 1'b0;
    endtask

    task automatic test_green_min();
        cur = "green_min";
        do_reset();
        push(P_GA, 0, 0); q2.push_back(P_GA);
        step(0, 0);
        sens_a = 1'b1; sens_b = 1'b1;
        push(P_GA, 0, 0);  q2.push_back(P_GA);
        push(P_YA, 0, 0);  q2.push_back(P_GA);
        push(P_RR1, 0, 0); q2.push_back(P_GA);
        push(P_GB, 0, 0);  q2.push_back(P_YA);
        for (int i = 0; i < 4; i++) step(0, 0);
        sens_a = 1'b0; sens_b = 1'b0;
    endtask

    task automatic test_ped();
        cur = "ped";
        do_reset();
        push(P_GA, 0, 0);
        step(0, 0);
        push(P_GA, 0, 0); push(P_YA, 0, 0); push(P_RR1, 0, 0); push(P_GB, 1, 0); push(P_GB, 0, 0);
        step(1, 0);
        for (int i = 0; i < 4; i++) step(0, 0);
        checks++;
        if (dut.pa_l_q !== 1'b0) begin
            errors++;
            $display("FAIL ped pa_l after GB entry: got %b want 0", dut.pa_l_q);
        end
        push(P_GB, 0, 0);
        step(0, 0);
        push(P_YB, 0, 0); push(P_RR2, 0, 0); push(P_GA, 0, 1); push(P_GA, 0, 0);
        step(0, 1);
        for (int i = 0; i < 3; i++) step(0, 0);
    endtask

    task automatic test_night();
        cur = "night";
        do_reset();
        push(P_GA, 0, 0); push(P_GA, 0, 0);
        step(0, 0); step(0, 0);
        modo = 1'b1;
        push(P_YA, 0, 0); push(P_RR1, 0, 0); push(P_NON, 0, 0); push(P_NOFF, 0, 0);
        push(P_NON, 0, 0); push(P_NOFF, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0);
        modo = 1'b0;
        push(P_RR1, 0, 0); push(P_GA, 0, 0); push(P_GA, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0);
    endtask

    task automatic test_back_to_back();
        cur = "rst_mid_yb";
        sens_a = 1'b1; sens_b = 1'b1;
        do_reset();
        push(P_GA, 0, 0); push(P_GA, 0, 0); push(P_YA, 0, 0); push(P_RR1, 0, 0);
        push(P_GB, 0, 0); push(P_GB, 0, 0); push(P_YB, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0);
        ped_a_req = 1'b1;
        @(negedge clk);
        ped_a_req = 1'b0;
        do_reset();
        push(P_GA, 0, 0); push(P_GA, 0, 0); push(P_YA, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0);
        cur = "rst_mid_non";
        sens_a = 1'b0; sens_b = 1'b0; modo = 1'b1;
        push(P_RR1, 0, 0); push(P_NON, 0, 0);
        step(0, 0); step(0, 0);
        ped_b_req = 1'b1;
        @(negedge clk);
        ped_b_req = 1'b0;
        modo = 1'b0;
        do_reset();
        push(P_GA, 0, 0); push(P_GA, 0, 0);
        step(0, 0); step(0, 0);
    endtask

    initial begin
        #2;
        test_reset();
        test_alternate();
        test_green_min();
        test_ped();
        test_night();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
